jet_tag_frame_sequencer: RTL and testbench

Sequencer between a streaming feature source and the jet-tagging inference core (`waiz_benchmark`, WIDTH=25, NFRAC=16, 16 in / 5 out). It assembles one feature per cycle into a 16-entry frame, fires the core's `input_ready` pulse, and supervises completion with a latency counter and timeout. It then captures the 5 class scores and streams them out over a valid/ready interface. It replaces direct array-wide pin drive at the top level.

---
 rtl/jet_tag_frame_sequencer_if.sv | 30 +++
 rtl/jet_tag_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_jet_tag_frame_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jet_tag_frame_sequencer_if.sv
// rtl/jet_tag_frame_sequencer_if.sv - feature-in / score-out stream bundle for the frame sequencer
//
// Purpose: groups the two valid/ready streams around the sequencer.
//   s_* : feature stream into the sequencer (s_last marks the final feature)
//   m_* : score stream out of the sequencer (m_last marks the final score)
// Modports:
//   master : the environment side (feature source and score sink)
//   slave  : the sequencer side
interface jet_tag_frame_sequencer_if #(
    parameter int WIDTH = 25
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/jet_tag_frame_sequencer.sv
// rtl/jet_tag_frame_sequencer.sv - frame assembler, core launcher and score streamer for the jet-tag core
//
// Purpose: collects INPUT_SIZE features into a frame buffer, pulses the core
// start, waits (bounded by TIMEOUT) for the core result, then streams the
// OUTPUT_SIZE scores out one per handshake.
// Ports:
//   clk, reset         : single rising-edge clock, synchronous active-high reset
//   bus (slave)        : s_valid/s_ready/s_data/s_last features in,
//                        m_valid/m_ready/m_data/m_last scores out
//   core_input_ready   : one-cycle start pulse to the core
//   core_input_data    : frame buffer presented to the core
//   core_output_ready  : core result valid (honoured only while waiting)
//   core_output_data   : core scores
//   busy               : frame in progress (including a partial frame)
//   latency            : cycles from start pulse to core result, last good frame
//   err_timeout        : sticky, core did not answer within TIMEOUT cycles
//   err_framing        : sticky, s_last seen at the wrong feature position
module jet_tag_frame_sequencer #(
    parameter int WIDTH       = 25,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 5,
    parameter int TIMEOUT     = 1023
) (
    input  logic                                  clk,
    input  logic                                  reset,
    jet_tag_frame_sequencer_if.slave              bus,
    output logic                                  core_input_ready,
    output logic [INPUT_SIZE-1:0][WIDTH-1:0]      core_input_data,
    input  logic                                  core_output_ready,
    input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]     core_output_data,
    output logic                                  busy,
    output logic [15:0]                           latency,
    output logic                                  err_timeout,
    output logic                                  err_framing
);

    localparam int IDX_W  = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
    localparam int OIDX_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INPUT_SIZE - 1);
    localparam logic [OIDX_W-1:0] OIDX_LAST = OIDX_W'(OUTPUT_SIZE - 1);
    localparam logic [15:0]       TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        LOAD,
        FIRE,
        WAIT,
        DRAIN
    } state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [IDX_W-1:0]                    idx;
    logic [OIDX_W-1:0]                   oidx;
    logic [15:0]                         cnt;
    logic [INPUT_SIZE-1:0][WIDTH-1:0]    ibuf;
    logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   obuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (bus.s_valid && (idx == IDX_LAST)) begin
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (core_output_ready) begin
                    state_nxt = DRAIN;
                end else if (cnt == TIMEOUT_C) begin
                    state_nxt = LOAD;
                end
            end
            DRAIN: begin
                if (bus.m_ready && (oidx == OIDX_LAST)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    assign bus.s_ready       = (state == LOAD);
    assign core_input_ready  = (state == FIRE);
    assign bus.m_valid       = (state == DRAIN);
    assign bus.m_data        = obuf[oidx];
    assign bus.m_last        = (state == DRAIN) && (oidx == OIDX_LAST);
    assign busy              = (state != LOAD) || (idx != '0);
    assign core_input_data   = ibuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            oidx        <= '0;
            cnt         <= '0;
            ibuf        <= '0;
            obuf        <= '0;
            latency     <= '0;
            err_timeout <= 1'b0;
            err_framing <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.s_valid) begin
                        ibuf[idx] <= bus.s_data;
                        if (idx == IDX_LAST) begin
                            // Full frame: fire regardless, but flag a missing s_last.
                            idx <= '0;
                            if (!bus.s_last) begin
                                err_framing <= 1'b1;
                            end
                        end else if (bus.s_last) begin
                            // Early s_last: the partial frame is thrown away.
                            idx         <= '0;
                            err_framing <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                FIRE: begin
                    cnt <= 16'd1;
                end
                WAIT: begin
                    if (core_output_ready) begin
                        obuf    <= core_output_data;
                        latency <= cnt;
                        oidx    <= '0;
                    end else if (cnt == TIMEOUT_C) begin
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    if (bus.m_ready) begin
                        oidx <= (oidx == OIDX_LAST) ? '0 : oidx + OIDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jet_tag_frame_sequencer.sv
// tb/tb_jet_tag_frame_sequencer.sv - self-checking bench for jet_tag_frame_sequencer
module tb_jet_tag_frame_sequencer;

    localparam int W   = 25;
    localparam int IN  = 16;
    localparam int OUT = 5;
    localparam int TO  = 20;

    typedef logic [IN-1:0][W-1:0]  frame_t;
    typedef logic [OUT-1:0][W-1:0] score_t;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        frame_t f;
        score_t sc;
        int     last_pos;
        int     dly;
        int     rm;
        int     exp_pulses;
        int     exp_lat;
        bit     exp_out;
        bit     exp_ferr;
        bit     exp_terr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_input_ready;
    frame_t      core_input_data;
    logic        core_output_ready;
    score_t      core_output_data;
    logic        busy;
    logic [15:0] latency;
    logic        err_timeout;
    logic        err_framing;

    always #5 clk = ~clk;

    jet_tag_frame_sequencer_if #(.WIDTH(W)) bus ();

    jet_tag_frame_sequencer #(
        .WIDTH(W), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .core_input_ready(core_input_ready),
        .core_input_data(core_input_data),
        .core_output_ready(core_output_ready),
        .core_output_data(core_output_data),
        .busy(busy),
        .latency(latency),
        .err_timeout(err_timeout),
        .err_framing(err_framing)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Core model: answers core_delay cycles after the start pulse (0 = never).
    int     core_delay = 0;
    score_t core_scores;
    int     core_cd = 0;
    int     pulses = 0;
    frame_t cap_in;
    bit     stray_en = 1'b0;

    initial begin
        core_output_ready = 1'b0;
        core_output_data  = '0;
        forever begin
            @(negedge clk);
            core_output_ready = 1'b0;
            if (reset) begin
                core_cd = 0;
            end else begin
                if (core_cd > 0) begin
                    core_cd--;
                    if (core_cd == 0) begin
                        core_output_ready = 1'b1;
                        core_output_data  = core_scores;
                    end
                end else if (stray_en && (bus.s_ready || bus.m_valid) && ($urandom_range(0, 7) == 0)) begin
                    core_output_ready = 1'b1;
                    for (int k = 0; k < OUT; k++) core_output_data[k] = W'($urandom);
                end
                if (core_input_ready) begin
                    pulses++;
                    cap_in = core_input_data;
                    if (core_delay > 0) core_cd = core_delay;
                end
            end
        end
    end

    // Score sink: 0 always ready, 1 pattern 1-0-0-1, 2 random, 3 ready for two beats only.
    beat_t        got[$];
    int           rmode = 0;
    int           rpat = 0;
    int           hs_cnt = 0;
    bit           stall_pend = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_l;

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_pend) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_data", bus.m_data, hold_d);
                chk("hold_last", bus.m_last, hold_l);
            end
            case (rmode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ((rpat % 4) == 0) || ((rpat % 4) == 3);
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = (hs_cnt < 2);
            endcase
            if (bus.m_valid) rpat++;
            stall_pend = bus.m_valid && !bus.m_ready && !reset;
            hold_d     = bus.m_data;
            hold_l     = bus.m_last;
            if (bus.m_valid && bus.m_ready && !reset) begin
                got.push_back('{d: bus.m_data, l: bus.m_last});
                hs_cnt++;
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] d, input bit last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        n = 0;
        while (!bus.s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) bound_fail("s_ready_wait");
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    int p0 = 0;

    // last_pos: 0..IN-2 early s_last, IN-1 normal, IN no s_last at all.
    task automatic send_frame(input frame_t f, input int last_pos, input int maxgap);
        int nb;
        nb = (last_pos < IN - 1) ? last_pos + 1 : IN;
        for (int i = 0; i < nb; i++) send_beat(f[i], (i == last_pos), $urandom_range(0, maxgap));
    endtask

    task automatic run_frame(input frame_t f, input score_t sc, input int last_pos,
                             input int dly, input int rm, input int maxgap);
        int n;
        core_delay  = dly;
        core_scores = sc;
        rmode       = rm;
        rpat        = 0;
        hs_cnt      = 0;
        got.delete();
        p0 = pulses;
        send_frame(f, last_pos, maxgap);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) bound_fail("frame_done_wait");
    endtask

    task automatic check_frame(input string tag, input frame_t f, input score_t sc, input int exp_pulses,
                               input int exp_lat, input bit exp_out, input bit exp_ferr, input bit exp_terr);
        chk({tag, ".pulses"}, pulses - p0, exp_pulses);
        if (exp_pulses != 0) begin
            for (int i = 0; i < IN; i++) chk({tag, ".core_in"}, cap_in[i], f[i]);
        end
        chk({tag, ".latency"}, latency, exp_lat);
        chk({tag, ".err_framing"}, err_framing, exp_ferr);
        chk({tag, ".err_timeout"}, err_timeout, exp_terr);
        chk({tag, ".n_scores"}, got.size(), exp_out ? OUT : 0);
        if (exp_out && got.size() == OUT) begin
            for (int k = 0; k < OUT; k++) begin
                chk({tag, ".m_data"}, got[k].d, sc[k]);
                chk({tag, ".m_last"}, got[k].l, (k == OUT - 1));
            end
        end
        chk({tag, ".s_ready"}, bus.s_ready, 1);
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < IN; i++) f[i] = W'($urandom);
        return f;
    endfunction

    function automatic score_t rand_scores();
        score_t s;
        for (int k = 0; k < OUT; k++) s[k] = W'($urandom);
        return s;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t   tbl[8];
        frame_t base_f;
        score_t base_s;
        int     n;
        int     m_lat;
        bit     m_ferr, m_terr;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        for (int i = 0; i < IN; i++) base_f[i] = W'(i + 1);
        for (int k = 0; k < OUT; k++) base_s[k] = W'(10 * (k + 1));

        tbl[0] = '{base_f,       base_s,        IN - 1, 7,  0, 1, 7,  1, 0, 0};
        tbl[1] = '{base_f,       base_s,        IN - 1, 7,  1, 1, 7,  1, 0, 0};
        tbl[2] = '{base_f,       base_s,        4,      3,  0, 0, 7,  0, 1, 0};
        tbl[3] = '{rand_frame(), rand_scores(), IN - 1, 5,  2, 1, 5,  1, 1, 0};
        tbl[4] = '{rand_frame(), rand_scores(), IN - 1, TO, 0, 1, TO, 1, 1, 0};
        tbl[5] = '{rand_frame(), rand_scores(), IN - 1, 0,  0, 1, TO, 0, 1, 1};
        tbl[6] = '{rand_frame(), rand_scores(), IN,     2,  1, 1, 2,  1, 1, 1};
        tbl[7] = '{rand_frame(), rand_scores(), IN - 1, 1,  2, 1, 1,  1, 1, 1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.s_ready", bus.s_ready, 1);
        chk("rst.m_valid", bus.m_valid, 0);
        chk("rst.core_input_ready", core_input_ready, 0);
        chk("rst.m_last", bus.m_last, 0);
        chk("rst.busy", busy, 0);
        chk("rst.latency", latency, 0);
        chk("rst.err_timeout", err_timeout, 0);
        chk("rst.err_framing", err_framing, 0);

        for (int v = 0; v < 8; v++) begin
            run_frame(tbl[v].f, tbl[v].sc, tbl[v].last_pos, tbl[v].dly, tbl[v].rm, 0);
            check_frame($sformatf("vec%0d", v), tbl[v].f, tbl[v].sc, tbl[v].exp_pulses,
                        tbl[v].exp_lat, tbl[v].exp_out, tbl[v].exp_ferr, tbl[v].exp_terr);
        end

        // Reset in the middle of DRAIN after two scores have gone out.
        core_delay = 3;
        core_scores = base_s;
        rmode = 3;
        rpat = 0;
        hs_cnt = 0;
        got.delete();
        send_frame(base_f, IN - 1, 0);
        n = 0;
        while (!(hs_cnt >= 2 && bus.m_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) bound_fail("drain_stall_wait");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid.m_valid", bus.m_valid, 0);
        chk("mid.busy", busy, 0);
        chk("mid.err_timeout", err_timeout, 0);
        chk("mid.err_framing", err_framing, 0);
        chk("mid.latency", latency, 0);
        chk("mid.s_ready", bus.s_ready, 1);
        chk("mid.n_scores", got.size(), 2);
        if (got.size() == 2) begin
            chk("mid.score0", got[0].d, 10);
            chk("mid.score1", got[1].d, 20);
        end

        run_frame(base_f, base_s, IN - 1, 7, 0, 0);
        check_frame("post_rst", base_f, base_s, 1, 7, 1, 0, 0);

        // Exact timeout cycle: flag visible TO cycles after the first WAIT cycle.
        core_delay = 0;
        rmode = 0;
        got.delete();
        send_frame(base_f, IN - 1, 0);
        chk("to.pulse", core_input_ready, 1);
        repeat (TO) @(negedge clk);
        chk("to.early_flag", err_timeout, 0);
        chk("to.still_busy", busy, 1);
        @(negedge clk);
        chk("to.flag", err_timeout, 1);
        chk("to.s_ready", bus.s_ready, 1);
        chk("to.m_valid", bus.m_valid, 0);
        chk("to.latency", latency, 7);
        chk("to.n_scores", got.size(), 0);

        // Randomised frames against a rule-level model.
        m_lat = 7;
        m_ferr = 1'b0;
        m_terr = 1'b1;
        stray_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            frame_t f;
            score_t s;
            int     lp, dly, r, ep;
            bit     eo;
            f = rand_frame();
            s = rand_scores();
            r = $urandom_range(0, 9);
            lp = (r == 0) ? $urandom_range(0, IN - 2) : (r == 1) ? IN : IN - 1;
            r = $urandom_range(0, 9);
            dly = (r == 0) ? 0 : (r == 1) ? $urandom_range(TO + 1, TO + 4) : $urandom_range(1, TO);
            ep = 0;
            eo = 1'b0;
            if (lp < IN - 1) begin
                m_ferr = 1'b1;
            end else begin
                ep = 1;
                if (lp == IN) m_ferr = 1'b1;
                if (dly >= 1 && dly <= TO) begin
                    m_lat = dly;
                    eo = 1'b1;
                end else begin
                    m_terr = 1'b1;
                end
            end
            run_frame(f, s, lp, dly, 2, 2);
            check_frame($sformatf("rnd%0d", t), f, s, ep, m_lat, eo, m_ferr, m_terr);
        end
        stray_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
